// File: rtl/pipelined_alu_if.sv
// Handshake and data bundle between an issuing master and the pipelined ALU.
// The ALU side connects through the slave modport. The producer/consumer side
// connects through the master modport.
interface pipelined_alu_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
);
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [3:0]       in_op_i;
    logic [XLEN-1:0]  in_rs1_i;
    logic [XLEN-1:0]  in_rs2_i;
    logic [TAG_W-1:0] in_tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  out_result_o;
    logic [TAG_W-1:0] out_tag_o;
    logic             out_err_o;
    logic [2:0]       occupancy_o;

    modport slave (
        input  flush_i, in_valid_i, in_op_i, in_rs1_i, in_rs2_i, in_tag_i, out_ready_i,
        output in_ready_o, out_valid_o, out_result_o, out_tag_o, out_err_o, occupancy_o
    );

    modport master (
        output flush_i, in_valid_i, in_op_i, in_rs1_i, in_rs2_i, in_tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_result_o, out_tag_o, out_err_o, occupancy_o
    );
endinterface

// File: rtl/pipelined_alu.sv
// Pipelined integer ALU with a fixed issue-to-result latency of STAGES cycles.
// The result is computed when an operation is accepted and captured into stage 1.
// Later stages only delay it. All stages stall together when the consumer
// back-pressures. Flush and reset clear only the stage valid bits.
module pipelined_alu #(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipelined_alu_if.slave    bus
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SLL  = 4'd2,  OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,  OP_XOR  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
        OP_OR   = 4'd8,  OP_AND  = 4'd9,  OP_ADDW = 4'd10, OP_SUBW = 4'd11,
        OP_SLLW = 4'd12, OP_SRLW = 4'd13, OP_SRAW = 4'd14, OP_PASS = 4'd15
    } op_e;

    op_e              w_op;
    logic [XLEN-1:0]  w_a;
    logic [XLEN-1:0]  w_b;
    logic [SHW-1:0]   w_shamt;
    logic [31:0]      w_word;
    logic             w_is_w;
    logic [XLEN-1:0]  w_res;
    logic             w_err;
    logic             w_stall;
    logic             w_accept;
    logic [2:0]       w_occ;

    logic [STAGES-1:0] r_valid;
    logic [XLEN-1:0]   r_res [STAGES];
    logic [TAG_W-1:0]  r_tag [STAGES];
    logic              r_err [STAGES];

    assign w_op     = op_e'(bus.in_op_i);
    assign w_a      = bus.in_rs1_i;
    assign w_b      = bus.in_rs2_i;
    assign w_shamt  = w_b[SHW-1:0];

    assign w_stall  = r_valid[STAGES-1] & ~bus.out_ready_i;
    assign w_accept = bus.in_valid_i & bus.in_ready_o;

    // Combinational ALU evaluated on the offered operands.
    // W ops compute a 32-bit word that is sign-extended afterwards. These ops are illegal when XLEN is 32.
    always_comb begin
        w_res  = '0;
        w_err  = 1'b0;
        w_word = '0;
        w_is_w = 1'b0;
        case (w_op)
            OP_ADD:  w_res = w_a + w_b;
            OP_SUB:  w_res = w_a - w_b;
            OP_SLL:  w_res = w_a << w_shamt;
            OP_SLT:  w_res = XLEN'($signed(w_a) < $signed(w_b));
            OP_SLTU: w_res = XLEN'(w_a < w_b);
            OP_XOR:  w_res = w_a ^ w_b;
            OP_SRL:  w_res = w_a >> w_shamt;
            OP_SRA:  w_res = $unsigned($signed(w_a) >>> w_shamt);
            OP_OR:   w_res = w_a | w_b;
            OP_AND:  w_res = w_a & w_b;
            OP_ADDW: begin w_is_w = 1'b1; w_word = w_a[31:0] + w_b[31:0]; end
            OP_SUBW: begin w_is_w = 1'b1; w_word = w_a[31:0] - w_b[31:0]; end
            OP_SLLW: begin w_is_w = 1'b1; w_word = w_a[31:0] << w_b[4:0]; end
            OP_SRLW: begin w_is_w = 1'b1; w_word = w_a[31:0] >> w_b[4:0]; end
            OP_SRAW: begin w_is_w = 1'b1; w_word = $unsigned($signed(w_a[31:0]) >>> w_b[4:0]); end
            default: w_res = w_a;
        endcase
        if (w_is_w) begin
            if (XLEN == 32) begin
                w_res = '0;
                w_err = 1'b1;
            end else begin
                w_res = XLEN'({{32{w_word[31]}}, w_word});
            end
        end
    end

    // Stage valid bits: reset and flush clear everything. Otherwise all stages shift together unless stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            r_valid <= '0;
        end else if (!w_stall) begin
            r_valid[0] <= w_accept;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Payload registers are not reset. They advance in lockstep with the valid bits.
    always_ff @(posedge clk_i) begin
        if (!w_stall) begin
            r_res[0] <= w_res;
            r_tag[0] <= bus.in_tag_i;
            r_err[0] <= w_err;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_res[i] <= r_res[i-1];
                r_tag[i] <= r_tag[i-1];
                r_err[i] <= r_err[i-1];
            end
        end
    end

    // Occupancy is a population count of the registered valid bits.
    always_comb begin
        w_occ = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            w_occ = w_occ + 3'(r_valid[i]);
        end
    end

    assign bus.in_ready_o   = rst_i | ~w_stall;
    assign bus.out_valid_o  = r_valid[STAGES-1];
    assign bus.out_result_o = r_res[STAGES-1];
    assign bus.out_tag_o    = r_tag[STAGES-1];
    assign bus.out_err_o    = r_valid[STAGES-1] & r_err[STAGES-1];
    assign bus.occupancy_o  = w_occ;
endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu.
// Instance A uses XLEN=64 and STAGES=2. It is tracked by an in-order scoreboard and also gets directed checks.
// Instance B uses XLEN=32 and STAGES=1. It gets directed and random checks.
module tb_pipelined_alu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_alu_if #(.XLEN(64), .TAG_W(6)) a_if ();
    pipelined_alu_if #(.XLEN(32), .TAG_W(6)) b_if ();

    pipelined_alu #(.XLEN(64), .STAGES(2), .TAG_W(6)) dut_a (.clk_i(clk), .rst_i(rst), .bus(a_if.slave));
    pipelined_alu #(.XLEN(32), .STAGES(1), .TAG_W(6)) dut_b (.clk_i(clk), .rst_i(rst), .bus(b_if.slave));

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned delivered = 0;

    typedef struct packed {
        logic [63:0] res;
        logic [5:0]  tag;
        logic        err;
    } exp_t;

    exp_t q[$];

    // Reference model. It returns {err, result} from the opcode table, using plain arithmetic for the given width.
    function automatic logic [64:0] model(int unsigned xlen, logic [3:0] op, logic [63:0] a_in, logic [63:0] b_in);
        logic [63:0] mask, a, b, r;
        logic signed [63:0] sa, sb;
        int unsigned sh;
        logic err;
        err  = 1'b0;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a = a_in & mask;
        b = b_in & mask;
        if (xlen == 64) begin
            sa = a;
            sb = b;
        end else begin
            sa = longint'(int'(a[31:0]));
            sb = longint'(int'(b[31:0]));
        end
        sh = 32'(b % 64'(xlen));
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a << sh;
            4'd3:  r = (sa < sb) ? 64'd1 : 64'd0;
            4'd4:  r = (a < b) ? 64'd1 : 64'd0;
            4'd5:  r = a ^ b;
            4'd6:  r = a >> sh;
            4'd7:  r = 64'(sa >>> sh);
            4'd8:  r = a | b;
            4'd9:  r = a & b;
            4'd15: r = a;
            default: begin
                if (xlen == 32) begin
                    err = 1'b1;
                    r   = 64'd0;
                end else begin
                    case (op)
                        4'd10:   r = longint'(int'(a[31:0] + b[31:0]));
                        4'd11:   r = longint'(int'(a[31:0] - b[31:0]));
                        4'd12:   r = longint'(int'(a[31:0] << b[4:0]));
                        4'd13:   r = longint'(int'(a[31:0] >> b[4:0]));
                        default: r = longint'(int'(a[31:0]) >>> b[4:0]);
                    endcase
                end
            end
        endcase
        return {err, r & mask};
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h0000_0000_8000_0000;
            3:       return 64'h0000_0000_7FFF_FFFF;
            4:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one operation on A and holds it until it is accepted (bounded wait).
    task automatic push_a(logic [3:0] op, logic [63:0] x, logic [63:0] y, logic [5:0] tag);
        logic took;
        took = 1'b0;
        a_if.in_valid_i = 1'b1;
        a_if.in_op_i    = op;
        a_if.in_rs1_i   = x;
        a_if.in_rs2_i   = y;
        a_if.in_tag_i   = tag;
        for (int n = 0; n < 50 && !took; n++) begin
            #1;
            took = a_if.in_ready_o;
            step();
        end
        a_if.in_valid_i = 1'b0;
        check("push_accept", 128'(took), 128'(1'b1));
    endtask

    task automatic a_single(string tag, logic [3:0] op, logic [63:0] x, logic [63:0] y, logic [63:0] exp);
        push_a(op, x, y, 6'd9);
        step();
        check(tag, 128'({a_if.out_valid_o, a_if.out_result_o}), 128'({1'b1, exp}));
    endtask

    // Single op on B (STAGES=1): the result is visible right after the acceptance edge.
    task automatic op_b(logic [3:0] op, logic [63:0] x, logic [63:0] y, logic [5:0] tag);
        logic [64:0] m;
        m = model(32, op, x, y);
        b_if.in_valid_i = 1'b1;
        b_if.in_op_i    = op;
        b_if.in_rs1_i   = x[31:0];
        b_if.in_rs2_i   = y[31:0];
        b_if.in_tag_i   = tag;
        step();
        b_if.in_valid_i = 1'b0;
        check("b_result", 128'({b_if.out_valid_o, b_if.out_result_o, b_if.out_tag_o, b_if.out_err_o}),
              128'({1'b1, m[31:0], tag, m[64]}));
    endtask

    // Scoreboard monitor for A. It samples mid-cycle, when the handshakes for the upcoming edge are settled.
    logic        prev_stall = 1'b0;
    logic [70:0] prev_out;
    always @(negedge clk) begin
        exp_t e;
        logic [64:0] m;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            check("occupancy", 128'(a_if.occupancy_o), 128'(q.size()));
            check("in_ready", 128'(a_if.in_ready_o), 128'(!(a_if.out_valid_o && !a_if.out_ready_i)));
            if (prev_stall)
                check("hold", 128'({a_if.out_valid_o, a_if.out_result_o, a_if.out_tag_o, a_if.out_err_o}),
                      128'({1'b1, prev_out}));
            if (a_if.out_valid_o && a_if.out_ready_i) begin
                if (q.size() == 0) begin
                    check("spurious_out", 128'(a_if.out_valid_o), 128'(1'b0));
                end else begin
                    e = q.pop_front();
                    check("a_result", 128'({a_if.out_result_o, a_if.out_tag_o, a_if.out_err_o}), 128'(e));
                    delivered++;
                end
            end
            prev_stall = a_if.out_valid_o && !a_if.out_ready_i && !a_if.flush_i;
            prev_out   = {a_if.out_result_o, a_if.out_tag_o, a_if.out_err_o};
            if (a_if.flush_i) begin
                q.delete();
            end else if (a_if.in_valid_i && a_if.in_ready_o) begin
                m = model(64, a_if.in_op_i, a_if.in_rs1_i, a_if.in_rs2_i);
                e.res = m[63:0];
                e.tag = a_if.in_tag_i;
                e.err = m[64];
                q.push_back(e);
            end
        end
    end

    initial begin
        int unsigned d0;
        rst = 1'b1;
        a_if.flush_i = 1'b0; a_if.in_valid_i = 1'b0; a_if.in_op_i = '0;
        a_if.in_rs1_i = '0; a_if.in_rs2_i = '0; a_if.in_tag_i = '0; a_if.out_ready_i = 1'b1;
        b_if.flush_i = 1'b0; b_if.in_valid_i = 1'b0; b_if.in_op_i = '0;
        b_if.in_rs1_i = '0; b_if.in_rs2_i = '0; b_if.in_tag_i = '0; b_if.out_ready_i = 1'b1;

        // Reset state.
        step();
        step();
        check("rst_out_valid", 128'(a_if.out_valid_o), 128'(1'b0));
        check("rst_occupancy", 128'(a_if.occupancy_o), 128'(3'd0));
        check("rst_err", 128'(a_if.out_err_o), 128'(1'b0));
        check("rst_b_valid", 128'(b_if.out_valid_o), 128'(1'b0));
        rst = 1'b0;
        #1;
        check("rst_in_ready", 128'(a_if.in_ready_o), 128'(1'b1));

        // ADD wraps to zero. Latency is two edges from the acceptance edge, counting that edge.
        push_a(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd5);
        check("add_not_early", 128'(a_if.out_valid_o), 128'(1'b0));
        step();
        check("add_wrap", 128'({a_if.out_valid_o, a_if.out_result_o, a_if.out_tag_o}), 128'({1'b1, 64'd0, 6'd5}));

        a_single("addw", 4'd10, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
        a_single("sraw", 4'd14, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000);
        a_single("slt",  4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
        a_single("sltu", 4'd4,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        step();
        step();

        // Back-to-back ops with three cycles of consumer back-pressure.
        d0 = delivered;
        push_a(4'd0, 64'd10, 64'd1, 6'd1);
        push_a(4'd1, 64'd10, 64'd3, 6'd2);
        check("b2b_first_valid", 128'(a_if.out_valid_o), 128'(1'b1));
        a_if.out_ready_i = 1'b0;
        a_if.in_valid_i = 1'b1; a_if.in_op_i = 4'd5; a_if.in_rs1_i = 64'hF0; a_if.in_rs2_i = 64'hFF; a_if.in_tag_i = 6'd3;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_in_ready", 128'(a_if.in_ready_o), 128'(1'b0));
            check("stall_occ", 128'(a_if.occupancy_o), 128'(3'd2));
            step();
        end
        a_if.out_ready_i = 1'b1;
        push_a(4'd5, 64'hF0, 64'hFF, 6'd3);
        push_a(4'd15, 64'h1234, 64'd0, 6'd4);
        step(); step(); step();
        check("b2b_delivered", 128'(delivered), 128'(d0 + 4));
        check("b2b_queue_empty", 128'(q.size()), 128'(0));

        // Flush with two in flight plus an offered op; the consumer is stalled, so nothing emerges.
        push_a(4'd0, 64'd1, 64'd2, 6'd10);
        push_a(4'd0, 64'd3, 64'd4, 6'd11);
        a_if.out_ready_i = 1'b0;
        a_if.flush_i = 1'b1;
        a_if.in_valid_i = 1'b1; a_if.in_op_i = 4'd0; a_if.in_tag_i = 6'd12;
        #1;
        check("flush_pre_occ", 128'(a_if.occupancy_o), 128'(3'd2));
        d0 = delivered;
        step();
        a_if.flush_i = 1'b0; a_if.in_valid_i = 1'b0; a_if.out_ready_i = 1'b1;
        check("flush_occ", 128'(a_if.occupancy_o), 128'(3'd0));
        check("flush_valid", 128'(a_if.out_valid_o), 128'(1'b0));
        step(); step(); step();
        check("flush_none_out", 128'(delivered), 128'(d0));

        // Flush while the consumer takes the head result: that handshake still counts.
        push_a(4'd0, 64'd5, 64'd6, 6'd13);
        push_a(4'd0, 64'd7, 64'd8, 6'd14);
        d0 = delivered;
        a_if.flush_i = 1'b1;
        a_if.in_valid_i = 1'b1; a_if.in_tag_i = 6'd15;
        step();
        a_if.flush_i = 1'b0; a_if.in_valid_i = 1'b0;
        check("flush_hs_delivered", 128'(delivered), 128'(d0 + 1));
        check("flush_hs_occ", 128'(a_if.occupancy_o), 128'(3'd0));

        // Reset while stalled with occupancy two.
        push_a(4'd0, 64'd1, 64'd1, 6'd20);
        push_a(4'd0, 64'd2, 64'd2, 6'd21);
        a_if.out_ready_i = 1'b0;
        a_if.in_valid_i = 1'b1; a_if.in_tag_i = 6'd22;
        rst = 1'b1;
        #1;
        check("rst_stall_in_ready", 128'(a_if.in_ready_o), 128'(1'b1));
        step();
        rst = 1'b0;
        a_if.in_valid_i = 1'b0;
        check("rst_stall_valid", 128'(a_if.out_valid_o), 128'(1'b0));
        check("rst_stall_occ", 128'(a_if.occupancy_o), 128'(3'd0));
        #1;
        check("rst_stall_in_ready_after", 128'(a_if.in_ready_o), 128'(1'b1));
        a_if.out_ready_i = 1'b1;
        step();

        // XLEN=32 instance: W ops are illegal, and full-width shifts use rs2[4:0].
        op_b(4'd11, 64'd9, 64'd4, 6'd33);
        check("b_subw_err", 128'({b_if.out_result_o, b_if.out_tag_o, b_if.out_err_o}), 128'({32'd0, 6'd33, 1'b1}));
        op_b(4'd7, 64'h8000_0000, 64'h21, 6'd34);
        check("b_sra", 128'({b_if.out_result_o, b_if.out_err_o}), 128'({32'hC000_0000, 1'b0}));
        for (int k = 0; k < 150; k++) begin
            op_b(4'($urandom), rnd64(), rnd64(), 6'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                step();
                check("b_idle", 128'(b_if.out_valid_o), 128'(1'b0));
            end
        end

        // Random traffic on A with back-pressure and occasional flush.
        for (int k = 0; k < 400; k++) begin
            a_if.in_valid_i  = ($urandom_range(0, 9) < 7);
            a_if.in_op_i     = 4'($urandom);
            a_if.in_rs1_i    = rnd64();
            a_if.in_rs2_i    = rnd64();
            a_if.in_tag_i    = 6'($urandom);
            a_if.out_ready_i = ($urandom_range(0, 9) < 7);
            a_if.flush_i     = ($urandom_range(0, 29) == 0);
            step();
        end
        a_if.in_valid_i = 1'b0; a_if.flush_i = 1'b0; a_if.out_ready_i = 1'b1;
        step(); step(); step(); step();
        check("drain_empty", 128'(q.size()), 128'(0));
        check("drain_valid", 128'(a_if.out_valid_o), 128'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipelined_alu.md
PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 Parameter XLEN, default 64: operand/result width; legal values 32 and 64 only.
REQ-002 Parameter STAGES, default 2: pipeline depth and fixed issue-to-result latency; legal values 1..4.
REQ-003 Parameter TAG_W, default 6: width of the sideband tag carried unchanged with each operation.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 flush_i  input  1  kills every in-flight operation.
REQ-007 in_valid_i  input  1  operation offered.
REQ-008 in_ready_o  output  1  operation accepted when in_valid_i & in_ready_o.
REQ-009 in_op_i  input  4  opcode, encoding per REQ-015.
REQ-010 in_rs1_i, in_rs2_i  input  XLEN  operands.
REQ-011 in_tag_i  input  TAG_W  sideband tag.
REQ-012 out_valid_o  output  1  result present; out_ready_i  input  1  consumer accepts.
REQ-013 out_result_o  output  XLEN; out_tag_o  output  TAG_W; out_err_o  output  1  illegal opcode for this XLEN.
REQ-014 occupancy_o  output  3  count of valid stages, 0..STAGES.

Function
REQ-015 Opcodes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 ADDW, 11 SUBW, 12 SLLW, 13 SRLW, 14 SRAW, 15 PASS (result = rs1).
REQ-016 Full-width shifts use rs2[log2(XLEN)-1:0]; SLT signed, SLTU unsigned, result zero-extended 0/1; arithmetic wraps modulo 2^XLEN.
REQ-017 W ops (XLEN=64): compute on [31:0], shift amount rs2[4:0], SRAW arithmetic on bit 31, result sign-extended from bit 31 into [63:32].
REQ-018 XLEN=32: opcodes 10..14 illegal -> result 0, out_err_o=1, tag still delivered; otherwise out_err_o=0.
REQ-019 Result computed combinationally at acceptance and captured into stage 1; stages 2..STAGES are pure delay registers; out_* driven from stage STAGES.
REQ-020 Latency: operation accepted at edge N appears on out_* after edge N+STAGES-1 when unstalled (valid in cycle N+STAGES-1 for STAGES=1 meaning visible the cycle after acceptance edge).
REQ-021 stall = out_valid_o & ~out_ready_i; when stall, all stages hold; in_ready_o = ~stall.
REQ-022 No bubble collapsing: empty intermediate stages advance together with full ones; throughput one op/cycle when out_ready_i=1.
REQ-023 Output held stable (result, tag, err) while out_valid_o=1 and out_ready_i=0.
REQ-024 flush_i=1: at next edge all stage valid bits clear; an operation handshaken in the same cycle is dropped; flush overrides stall; out_valid_o may be 1 in flush cycle and consumer handshake in that cycle is still valid.
REQ-025 occupancy_o = number of set stage valid bits, registered-state derived, updates same edge as stages.
REQ-026 Data/tag registers need not reset; only valid bits are reset.

Reset
REQ-027 rst_i=1 at an edge clears all valid bits: out_valid_o=0, occupancy_o=0, out_err_o=0 next cycle.
REQ-028 rst_i has priority over flush_i and handshakes; input accepted during reset cycle is dropped; in_ready_o=1 during and after reset.

Verification
REQ-029 XLEN=64, STAGES=2, out_ready=1: ADD 0xFFFF_FFFF_FFFF_FFFF + 1 tag 5 -> result 0, tag 5, valid 2 edges after acceptance.
REQ-030 ADDW 0x7FFF_FFFF + 1 -> 0xFFFF_FFFF_8000_0000; SRAW 0x8000_0000 by 4 -> 0xFFFF_FFFF_F800_0000; SLT -1 vs 1 -> 1, SLTU -> 0.
REQ-031 Back-to-back 4 ops, out_ready low 3 cycles once first valid -> in_ready_o low, output frozen, occupancy_o=2, all 4 delivered in order with no loss or duplication.
REQ-032 Flush with occupancy 2 plus simultaneous new input -> next cycle occupancy_o=0, out_valid_o=0, none of the 3 ops emerge.
REQ-033 XLEN=32, SUBW -> result 0, out_err_o=1; SRA 0x8000_0000 by rs2=0x21 -> 0xC000_0000 (amount 1).
REQ-034 rst_i asserted with occupancy 2 and stall -> next cycle out_valid_o=0, occupancy_o=0, in_ready_o=1.
